// File: rtl/player_pixel_reader.sv
// Player sprite pixel reader: frame-latched shadows, 2-stage pixel pipe.
// Optional collision flag compiled in when PLAYER_COLLISION_EN is defined.
module player_pixel_reader #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [3:0]  TRANSPARENT = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        videoOn,
    input  logic [3:0]  bgColor,
    input  logic [31:0] player_hStartPos,
    input  logic [31:0] player_vStartPos,
    input  logic [31:0] player_hOffset,
    input  logic [31:0] player_vOffset,
    input  logic [31:0] player_objWidth,
    input  logic [31:0] player_objHeight,
    input  logic [3:0]  player_color,
    input  logic        collisionAck,
    output logic [3:0]  pixelColor,
    output logic        pixelValid,
    output logic        playerHit,
    output logic        collision
);

    typedef enum logic {WAIT_FRAME, DRAW} state_t;

    state_t      r_state;
    logic [32:0] r_left;
    logic [32:0] r_top;
    logic [31:0] r_width;
    logic [31:0] r_height;
    logic [3:0]  r_color;

    logic        r_s1_inside;
    logic        r_s1_von;
    logic [3:0]  r_s1_bg;

    logic        w_fl;
    logic [32:0] w_h;
    logic [32:0] w_v;
    logic [33:0] w_right;
    logic [33:0] w_bottom;
    logic        w_in_h;
    logic        w_in_v;
    logic        w_area;
    logic        w_inside;

    // Frame latch fires as the scan enters the first blanking line
    assign w_fl = (hCount == 10'd0) && (vCount == 10'(V_ACTIVE));

    assign w_h      = {23'd0, hCount};
    assign w_v      = {23'd0, vCount};
    // Right/bottom edges carry an extra bit so origin+size never wraps
    assign w_right  = {1'b0, r_left} + {2'b0, r_width};
    assign w_bottom = {1'b0, r_top} + {2'b0, r_height};
    assign w_in_h   = (w_h >= r_left) && ({1'b0, w_h} < w_right);
    assign w_in_v   = (w_v >= r_top) && ({1'b0, w_v} < w_bottom);
    assign w_area   = (int'({22'd0, hCount}) < H_ACTIVE);
    assign w_inside = w_in_h && w_in_v && w_area;

    // Frame FSM and shadow registers, reloaded on every frame latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT_FRAME;
            r_left   <= '0;
            r_top    <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_color  <= '0;
        end else begin
            case (r_state)
                WAIT_FRAME: if (w_fl) r_state <= DRAW;
                DRAW:       r_state <= DRAW;
                default:    r_state <= WAIT_FRAME;
            endcase
            if (w_fl) begin
                r_left   <= {1'b0, player_hStartPos} + {1'b0, player_hOffset};
                r_top    <= {1'b0, player_vStartPos} + {1'b0, player_vOffset};
                r_width  <= player_objWidth;
                r_height <= player_objHeight;
                r_color  <= player_color;
            end
        end
    end

    // Stage 1: hit test and alignment of videoOn/background
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_inside <= 1'b0;
            r_s1_von    <= 1'b0;
            r_s1_bg     <= '0;
        end else begin
            r_s1_inside <= w_inside && videoOn && (r_state == DRAW);
            r_s1_von    <= videoOn;
            r_s1_bg     <= bgColor;
        end
    end

    // Stage 2: composite player over background
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixelColor <= '0;
            pixelValid <= 1'b0;
            playerHit  <= 1'b0;
        end else begin
            pixelColor <= r_s1_inside ? r_color :
                          (r_s1_von ? r_s1_bg : 4'd0);
            pixelValid <= r_s1_von;
            playerHit  <= r_s1_inside;
        end
    end

`ifdef PLAYER_COLLISION_EN
    logic r_frameHit;
    logic r_collision;

    assign collision = r_collision;

    // Per-frame hit accumulator folded into the sticky flag at frame latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameHit  <= 1'b0;
            r_collision <= 1'b0;
        end else if (w_fl) begin
            r_frameHit  <= 1'b0;
            r_collision <= r_frameHit | (r_collision & ~collisionAck);
        end else begin
            if (r_s1_inside && (r_s1_bg != TRANSPARENT))
                r_frameHit <= 1'b1;
            r_collision <= r_collision & ~collisionAck;
        end
    end
`else
    logic w_unused_cfg;

    assign collision    = 1'b0;
    assign w_unused_cfg = ^{collisionAck, TRANSPARENT};
`endif

endmodule

// File: tb/tb_player_pixel_reader.sv
// Directed bench for player_pixel_reader: reset, geometry, move, size,
// and collision (flag expected low when PLAYER_COLLISION_EN is undefined).
module tb_player_pixel_reader;

`ifdef PLAYER_COLLISION_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic        videoOn = 1'b0;
    logic [3:0]  bgColor = '0;
    logic [31:0] hStart = 32'd308;
    logic [31:0] vStart = 32'd396;
    logic [31:0] hOff = '0;
    logic [31:0] vOff = '0;
    logic [31:0] wid = 32'd12;
    logic [31:0] hgt = 32'd12;
    logic [3:0]  pcol = 4'd2;
    logic        ack = 1'b0;
    logic [3:0]  pixelColor;
    logic        pixelValid;
    logic        playerHit;
    logic        collision;

    int n_checks = 0;
    int n_errors = 0;

    player_pixel_reader dut (
        .clk              (clk),
        .rst              (rst),
        .hCount           (hCount),
        .vCount           (vCount),
        .videoOn          (videoOn),
        .bgColor          (bgColor),
        .player_hStartPos (hStart),
        .player_vStartPos (vStart),
        .player_hOffset   (hOff),
        .player_vOffset   (vOff),
        .player_objWidth  (wid),
        .player_objHeight (hgt),
        .player_color     (pcol),
        .collisionAck     (ack),
        .pixelColor       (pixelColor),
        .pixelValid       (pixelValid),
        .playerHit        (playerHit),
        .collision        (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one pixel and wait out the 2-clk pipeline
    task automatic px(input int h, input int v, input logic von,
                      input logic [3:0] bg);
        @(negedge clk);
        hCount  = 10'(h);
        vCount  = 10'(v);
        videoOn = von;
        bgColor = bg;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pxc(input string tag, input int h, input int v,
                       input logic von, input logic [3:0] bg,
                       input int col, input int hit);
        px(h, v, von, bg);
        check({tag, ".color"}, 32'(pixelColor), 32'(col));
        check({tag, ".hit"}, 32'(playerHit), 32'(hit));
        check({tag, ".valid"}, 32'(pixelValid), 32'(von));
    endtask

    // One frame-latch cycle, optionally with ack in the same cycle
    task automatic fl(input logic a);
        @(negedge clk);
        hCount  = 10'd0;
        vCount  = 10'd480;
        videoOn = 1'b0;
        bgColor = 4'd0;
        ack     = a;
        @(posedge clk);
        #1;
        hCount = 10'd1;
        ack    = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.color", 32'(pixelColor), 32'd0);
        check("rst.valid", 32'(pixelValid), 32'd0);
        check("rst.coll", 32'(collision), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Before any frame latch only background shows
        pxc("pre", 100, 50, 1'b1, 4'd7, 7, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.color", 32'(pixelColor), 32'd0);
        check("midrst.valid", 32'(pixelValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pxc("nofl", 310, 400, 1'b1, 4'd0, 0, 0);

        // Geometry of the 12x12 box at (308,396)
        fl(1'b0);
        pxc("g.tl", 308, 396, 1'b1, 4'd0, 2, 1);
        pxc("g.br", 319, 407, 1'b1, 4'd0, 2, 1);
        pxc("g.tr", 319, 396, 1'b1, 4'd0, 2, 1);
        pxc("g.r", 320, 396, 1'b1, 4'd0, 0, 0);
        pxc("g.l", 307, 396, 1'b1, 4'd0, 0, 0);
        pxc("g.t", 308, 395, 1'b1, 4'd0, 0, 0);
        pxc("g.b", 308, 408, 1'b1, 4'd0, 0, 0);
        pxc("g.bg", 320, 400, 1'b1, 4'd9, 9, 0);
        pxc("g.off", 310, 400, 1'b0, 4'd0, 0, 0);

        // Exactly two clocks of latency
        pxc("lat.pre", 320, 400, 1'b1, 4'd9, 9, 0);
        @(negedge clk);
        hCount  = 10'd310;
        vCount  = 10'd400;
        bgColor = 4'd0;
        @(posedge clk);
        #1;
        check("lat.1clk", 32'(pixelColor), 32'd9);
        @(posedge clk);
        #1;
        check("lat.2clk", 32'(pixelColor), 32'd2);

        // Mid-frame move waits for the next latch
        pxc("mv.v200", 100, 200, 1'b1, 4'd0, 0, 0);
        hOff = 32'd40;
        pxc("mv.old", 310, 400, 1'b1, 4'd0, 2, 1);
        pxc("mv.newx", 348, 400, 1'b1, 4'd0, 0, 0);
        check("mv.coll0", 32'(collision), 32'd0);
        fl(1'b0);
        pxc("mv.l", 348, 400, 1'b1, 4'd0, 2, 1);
        pxc("mv.br", 359, 407, 1'b1, 4'd0, 2, 1);
        pxc("mv.r", 360, 400, 1'b1, 4'd0, 0, 0);
        pxc("mv.ll", 347, 400, 1'b1, 4'd0, 0, 0);
        pxc("mv.gone", 310, 400, 1'b1, 4'd0, 0, 0);

        // Collision against opaque background
        pxc("c.px", 350, 400, 1'b1, 4'd5, 2, 1);
        check("c.prefl", 32'(collision), 32'd0);
        fl(1'b0);
        check("c.set", 32'(collision), 32'(CE));
        pxc("c.hold", 100, 100, 1'b1, 4'd0, 0, 0);
        check("c.sticky", 32'(collision), 32'(CE));
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("c.ack", 32'(collision), 32'd0);
        pxc("c.px2", 350, 400, 1'b1, 4'd5, 2, 1);
        fl(1'b1);
        check("c.setwins", 32'(collision), 32'(CE));
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("c.ack2", 32'(collision), 32'd0);
        fl(1'b0);
        check("c.cleared", 32'(collision), 32'd0);

        // Zero width never hits
        wid = 32'd0;
        fl(1'b0);
        pxc("z.l", 348, 400, 1'b1, 4'd0, 0, 0);
        pxc("z.bg", 350, 400, 1'b1, 4'd5, 5, 0);
        fl(1'b0);
        check("z.coll", 32'(collision), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/player_pixel_reader.md
# player_pixel_reader

Consumer end of the player-object interface: takes the player rectangle description (start position, size, offset, colour) and the VGA scan counters, and produces the per-pixel colour that the display mux draws. Position inputs are captured into shadow registers once per frame, so a mid-frame move never tears the sprite. The block also detects overlap between the player and a non-transparent background pixel, and reports it as a sticky, acknowledgeable collision flag. It sits between the player object and the VGA colour output mux.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- TRANSPARENT, 4'd0, colour code meaning "no pixel"

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hCount  in  10  current column from VGA timing
- vCount  in  10  current line from VGA timing
- videoOn  in  1  visible-area flag, aligned with hCount/vCount
- bgColor  in  4  background-layer colour at (hCount, vCount), aligned
- player_hStartPos, player_vStartPos  in  32  rectangle origin
- player_hOffset, player_vOffset  in  32  movement offset added to origin
- player_objWidth, player_objHeight  in  32  rectangle size
- player_color  in  4  player colour
- collisionAck  in  1  clears the sticky collision flag
- pixelColor  out  4  composited colour
- pixelValid  out  1  videoOn delayed to match pixelColor
- playerHit  out  1  player covers the output pixel
- collision  out  1  sticky collision flag

## Operation
- Frame latch event (FL): hCount==0 && vCount==V_ACTIVE. Also fires when the scan enters the first blanking line.
- On FL, the shadow registers load the following:
  - left = hStartPos + hOffset
  - top = vStartPos + vOffset
  - width, height and colour
- Both sums are 33-bit, with no wrap.
- Between FL events, the shadow registers hold their value regardless of input changes.
- FSM has two states:
  - WAIT_FRAME: reset state. Outputs draw nothing. Moves to DRAW on the first FL.
  - DRAW: stays in DRAW. Every FL reloads the shadows.
- Inside test, done in 33-bit unsigned:
  - left <= hCount < left+width, and
  - top <= vCount < top+height.
- Edges: right and bottom are exclusive. Width or height of 0 draws nothing. Pixels beyond H_ACTIVE/V_ACTIVE are never drawn, because videoOn is 0 there.
- Stage 1 registers the following:
  - inside & videoOn & (state==DRAW)
  - videoOn
  - bgColor
- Stage 2 rules:
  - pixelColor = player colour if inside, else bgColor if videoOn, else 0.
  - playerHit = inside.
  - pixelValid = videoOn.
- Collision rules:
  - frameHit sets when a stage-1 pixel is inside and bgColor != TRANSPARENT.
  - On FL, collision <= collision | frameHit, and frameHit clears.
  - collisionAck clears collision.
  - If the FL set and collisionAck occur in the same cycle, the set wins.

## Timing
- Latency is 2 clk from hCount/vCount/videoOn/bgColor to pixelColor/pixelValid/playerHit.
- New position data is visible starting with the first visible pixel after the FL on which it was captured. Inputs must be stable on the FL cycle.
- collision rises 1 clk after the FL cycle that ends the offending frame.
- Reset (async, any time, including mid-line) forces:
  - pixelColor=0, pixelValid=0, playerHit=0, collision=0
  - frameHit=0, pipeline cleared, all shadows 0
  - state WAIT_FRAME
- After reset, nothing is drawn until the next FL.

## Configuration
- PLAYER_COLLISION_EN defined: frameHit and collision logic are compiled in, as specified above.
- PLAYER_COLLISION_EN undefined: frameHit is removed, collision is tied to 0, and collisionAck is ignored. Pixel path and timing are unchanged.

## Test plan
- Reset mid-line: assert rst at hCount=100/vCount=50. All outputs are 0 at once. Release rst. No player pixel appears before vCount=480 FL.
- Geometry check:
  - Setup: hStart=308, vStart=396, offsets 0, 12x12, colour 2, bgColor=0.
  - Required: after FL, pixelColor=2 exactly for hCount 308..319 and vCount 396..407, each 2 clk after the counter value.
  - Required: pixelColor=0 at hCount=320.
- Mid-frame move: change hOffset to 40 at vCount=200. The current frame is unchanged. The next frame draws at hCount 348..359.
- Zero size: width=0. No playerHit during the whole frame.
- Collision (with PLAYER_COLLISION_EN):
  - Setup: bgColor=5 under the rectangle.
  - Required: collision=1 one clk after the next FL, and it stays 1.
  - Required: collisionAck clears it.
  - Required: ack asserted in the same cycle as an FL set leaves collision=1.
- Collision (without PLAYER_COLLISION_EN): same stimulus as above. collision stays 0, and pixelColor is identical to the enabled build.
